uart_byte_buffer: RTL and testbench
===================================

# uart_byte_buffer

Parametrised synchronous ring buffer that sits between the UART receive path and the byte consumer, replacing the flat write-addressed data store. Incoming bytes are written sequentially at an internal write pointer and drained in arrival order through a registered read port with a valid strobe. Occupancy, full/empty and sticky overflow/underflow status are provided, and there is a synchronous clear. No tri-state outputs are used.

## Interface
- DATA_W, 8, data word width in bits
- DEPTH, 1024, number of storage entries; any integer ≥ 2, not required to be a power of two
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden
- CNT_W, $clog2(DEPTH+1), level width; derived, not overridden
- clk  input  1  single clock; all state is updated on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear of pointers, level and flags
- wr_en  input  1  write request for this cycle
- wr_data  input  DATA_W  data to store when the write is accepted
- rd_en  input  1  read (pop) request for this cycle
- rd_data  output  DATA_W  registered read data
- rd_valid  output  1  one-cycle strobe qualifying rd_data
- level  output  CNT_W  number of stored entries, 0..DEPTH
- empty  output  1  level == 0
- full  output  1  level == DEPTH
- overflow  output  1  sticky: a write was rejected because the buffer was full
- underflow  output  1  sticky: a read was rejected because the buffer was empty

## Operation
- Storage is an array of DEPTH × DATA_W entries. The array contents are not reset or cleared, only the pointers.
- wr_ptr and rd_ptr are ADDR_W wide. Each pointer advances by 1 on an accepted access and wraps from DEPTH-1 to 0 by explicit compare, not by modulo-2^ADDR_W.
- Write accept is wr_en && (!full || rd_accept). When accepted, mem[wr_ptr] <= wr_data and wr_ptr advances.
- Read accept (rd_accept) is rd_en && !empty. When accepted, rd_data <= mem[rd_ptr], rd_valid <= 1 and rd_ptr advances. Otherwise rd_valid <= 0 and rd_data holds its value.
- Level update:
  - +1 on write-only accept
  - −1 on read-only accept
  - unchanged when both accept or neither accepts
- When full, a simultaneous read and write are both accepted and level stays at DEPTH.
- When empty, a simultaneous read and write accept the write only. The read is rejected, underflow is set, and rd_valid is 0. There is no fall-through.
- wr_en while full with no accepted read: the write is dropped, overflow <= 1, and pointers and level are unchanged.
- rd_en while empty: underflow <= 1 and state is otherwise unchanged.
- overflow and underflow stay set until clr or reset.
- clr has priority over wr_en and rd_en in the same cycle. It sets both pointers to 0, level to 0, overflow to 0, underflow to 0 and rd_valid to 0. rd_data holds its value. Both the write and the read in that cycle are discarded.
- empty and full are derived from the registered level, so they are always coherent with level.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - rd_data = 0, rd_valid = 0
  - level = 0, empty = 1, full = 0
  - overflow = 0, underflow = 0
  - wr_ptr = 0, rd_ptr = 0
- Release of rst_n is synchronised by the top level. The block takes no action on the release edge other than normal operation.
- Read latency is 1 cycle. For rd_en sampled at edge N, rd_data and rd_valid are valid after edge N for exactly one cycle unless another read is accepted at edge N+1.
- Back-to-back reads every cycle give one byte per cycle with rd_valid continuously high.
- Write-to-read latency: a byte written at edge N is readable by rd_en sampled at edge N+1, with data out after N+1. empty deasserts after edge N.
- level, empty, full and the sticky flags all update on the same edge as the access that changes them.
- If rst_n is asserted mid-operation, all state aborts immediately. Pending rd_valid drops asynchronously.

## Test plan
- Reset then idle (DEPTH=4): after rst_n rises, empty=1, full=0, level=0, rd_valid=0 and rd_data=0 for 10 cycles.
- Fill and drain (DEPTH=4): write 0x11, 0x22, 0x33, 0x44 on consecutive cycles, giving full=1 and level=4. Then read 4 consecutive cycles: rd_data is 0x11, 0x22, 0x33, 0x44 with rd_valid high for 4 cycles, then empty=1.
- Overflow/underflow (DEPTH=4): when full, write 0x55 → overflow=1, level=4, and a subsequent drain returns 0x11..0x44 with no 0x55. Then rd_en while empty → underflow=1, rd_valid=0. Both flags persist until clr.
- Simultaneous access (DEPTH=4):
  - When full, rd_en and wr_en(0xAA) in the same cycle → rd_data=0x11, level stays 4, and 0xAA is read last.
  - When empty, both asserted → level=1, rd_valid=0, underflow=1.
- Wrap-around with DEPTH=5 (non-power-of-two): 12 write/read pairs with data 0x00..0x0B come out in order, verifying pointer wrap 4→0.
- Clear and reset mid-operation: with level=3, assert clr together with wr_en and rd_en → next cycle level=0, empty=1, rd_valid=0 and flags cleared. Assert rst_n low asynchronously between edges → outputs reach reset values before the next edge.

Source files
------------

// File: rtl/uart_byte_buffer_if.sv
// Handshake and status bundle between the UART receive path and the byte buffer.
// The producer/consumer side holds the master modport; the buffer holds the slave modport.
interface uart_byte_buffer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 1024
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              clr;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  level;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, level, empty, full, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, level, empty, full, overflow, underflow
    );
endinterface

// File: rtl/uart_byte_buffer.sv
// Ring buffer for received UART bytes: sequential writes, in-order registered reads,
// occupancy with full/empty, sticky overflow/underflow and a synchronous clear.
module uart_byte_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 1024
) (
    input logic                clk,
    input logic                rst_n,
    uart_byte_buffer_if.slave  bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic empty, full;
    logic rd_accept, wr_accept;
    logic mem_we;

    // Explicit wrap so non-power-of-two depths never address past DEPTH-1.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
    endfunction

    assign empty = (level_q == '0);
    assign full  = (level_q == CNT_W'(DEPTH));

    // A full buffer still takes a write when a read frees a slot in the same cycle.
    assign rd_accept = bus.rd_en && !empty;
    assign wr_accept = bus.wr_en && (!full || rd_accept);
    assign mem_we    = wr_accept && !bus.clr;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_accept) begin
                rd_ptr_d   = ptr_inc(rd_ptr_q);
                rd_data_d  = mem[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   level_d = level_q + CNT_W'(1);
                2'b01:   level_d = level_q - CNT_W'(1);
                default: level_d = level_q;
            endcase
            if (bus.wr_en && !wr_accept) begin
                overflow_d = 1'b1;
            end
            if (bus.rd_en && !rd_accept) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset and clear.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.level     = level_q;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_uart_byte_buffer.sv
// Directed bench for uart_byte_buffer: a DEPTH=4 instance for fill/drain/flags/clear
// and a DEPTH=5 instance for pointer wrap on a non-power-of-two depth.
module tb_uart_byte_buffer;
    logic clk;
    logic rst_n;

    int vectors;
    int errs;

    uart_byte_buffer_if #(.DATA_W(8), .DEPTH(4)) bus_a ();
    uart_byte_buffer_if #(.DATA_W(8), .DEPTH(5)) bus_b ();

    uart_byte_buffer #(.DATA_W(8), .DEPTH(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    uart_byte_buffer #(.DATA_W(8), .DEPTH(5)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.clr   = 1'b0;
        bus_a.wr_en = 1'b0;
        bus_a.rd_en = 1'b0;
    endtask

    task automatic write_a(input logic [7:0] d);
        bus_a.wr_en   = 1'b1;
        bus_a.wr_data = d;
        bus_a.rd_en   = 1'b0;
        tick();
        bus_a.wr_en = 1'b0;
    endtask

    task automatic read_a(input string tag, input logic [7:0] d);
        bus_a.rd_en = 1'b1;
        tick();
        bus_a.rd_en = 1'b0;
        chk({tag, "_data"}, 32'(bus_a.rd_data), 32'(d));
        chk({tag, "_valid"}, 32'(bus_a.rd_valid), 32'd1);
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst_n   = 1'b0;
        idle_a();
        bus_a.wr_data = 8'h00;
        bus_b.clr     = 1'b0;
        bus_b.wr_en   = 1'b0;
        bus_b.rd_en   = 1'b0;
        bus_b.wr_data = 8'h00;

        // Reset then idle
        repeat (3) tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_empty", 32'(bus_a.empty), 32'd1);
            chk("idle_full", 32'(bus_a.full), 32'd0);
            chk("idle_level", 32'(bus_a.level), 32'd0);
            chk("idle_valid", 32'(bus_a.rd_valid), 32'd0);
            chk("idle_data", 32'(bus_a.rd_data), 32'd0);
        end

        // Fill and drain
        write_a(8'h11);
        chk("fill1_empty", 32'(bus_a.empty), 32'd0);
        chk("fill1_level", 32'(bus_a.level), 32'd1);
        write_a(8'h22);
        write_a(8'h33);
        write_a(8'h44);
        chk("fill_full", 32'(bus_a.full), 32'd1);
        chk("fill_level", 32'(bus_a.level), 32'd4);
        bus_a.rd_en = 1'b1;
        tick();
        chk("drain0", 32'(bus_a.rd_data), 32'h11);
        chk("drain0_v", 32'(bus_a.rd_valid), 32'd1);
        tick();
        chk("drain1", 32'(bus_a.rd_data), 32'h22);
        chk("drain1_v", 32'(bus_a.rd_valid), 32'd1);
        tick();
        chk("drain2", 32'(bus_a.rd_data), 32'h33);
        chk("drain2_v", 32'(bus_a.rd_valid), 32'd1);
        tick();
        bus_a.rd_en = 1'b0;
        chk("drain3", 32'(bus_a.rd_data), 32'h44);
        chk("drain3_v", 32'(bus_a.rd_valid), 32'd1);
        chk("drain_empty", 32'(bus_a.empty), 32'd1);
        chk("drain_level", 32'(bus_a.level), 32'd0);
        tick();
        chk("drain_v_drop", 32'(bus_a.rd_valid), 32'd0);

        // Overflow / underflow
        write_a(8'h11);
        write_a(8'h22);
        write_a(8'h33);
        write_a(8'h44);
        write_a(8'h55);
        chk("ovf_flag", 32'(bus_a.overflow), 32'd1);
        chk("ovf_level", 32'(bus_a.level), 32'd4);
        chk("ovf_full", 32'(bus_a.full), 32'd1);
        read_a("ovf_rd0", 8'h11);
        read_a("ovf_rd1", 8'h22);
        read_a("ovf_rd2", 8'h33);
        read_a("ovf_rd3", 8'h44);
        chk("ovf_empty", 32'(bus_a.empty), 32'd1);
        bus_a.rd_en = 1'b1;
        tick();
        bus_a.rd_en = 1'b0;
        chk("udf_flag", 32'(bus_a.underflow), 32'd1);
        chk("udf_valid", 32'(bus_a.rd_valid), 32'd0);
        chk("udf_data_hold", 32'(bus_a.rd_data), 32'h44);
        chk("udf_level", 32'(bus_a.level), 32'd0);
        repeat (3) tick();
        chk("ovf_sticky", 32'(bus_a.overflow), 32'd1);
        chk("udf_sticky", 32'(bus_a.underflow), 32'd1);
        bus_a.clr = 1'b1;
        tick();
        bus_a.clr = 1'b0;
        chk("clr_ovf", 32'(bus_a.overflow), 32'd0);
        chk("clr_udf", 32'(bus_a.underflow), 32'd0);

        // Simultaneous access when full
        write_a(8'h11);
        write_a(8'h22);
        write_a(8'h33);
        write_a(8'h44);
        bus_a.rd_en   = 1'b1;
        bus_a.wr_en   = 1'b1;
        bus_a.wr_data = 8'hAA;
        tick();
        idle_a();
        chk("simf_data", 32'(bus_a.rd_data), 32'h11);
        chk("simf_valid", 32'(bus_a.rd_valid), 32'd1);
        chk("simf_level", 32'(bus_a.level), 32'd4);
        chk("simf_ovf", 32'(bus_a.overflow), 32'd0);
        read_a("simf_rd1", 8'h22);
        read_a("simf_rd2", 8'h33);
        read_a("simf_rd3", 8'h44);
        read_a("simf_rd4", 8'hAA);
        chk("simf_empty", 32'(bus_a.empty), 32'd1);

        // Simultaneous access when empty: write only, no fall-through
        bus_a.rd_en   = 1'b1;
        bus_a.wr_en   = 1'b1;
        bus_a.wr_data = 8'hBB;
        tick();
        idle_a();
        chk("sime_level", 32'(bus_a.level), 32'd1);
        chk("sime_valid", 32'(bus_a.rd_valid), 32'd0);
        chk("sime_udf", 32'(bus_a.underflow), 32'd1);
        chk("sime_data_hold", 32'(bus_a.rd_data), 32'hAA);
        read_a("sime_rd", 8'hBB);

        // Clear together with write and read at level 3
        write_a(8'h01);
        write_a(8'h02);
        write_a(8'h03);
        chk("clr_pre_level", 32'(bus_a.level), 32'd3);
        bus_a.clr     = 1'b1;
        bus_a.wr_en   = 1'b1;
        bus_a.rd_en   = 1'b1;
        bus_a.wr_data = 8'hCC;
        tick();
        idle_a();
        chk("clr_level", 32'(bus_a.level), 32'd0);
        chk("clr_empty", 32'(bus_a.empty), 32'd1);
        chk("clr_valid", 32'(bus_a.rd_valid), 32'd0);
        chk("clr_udf2", 32'(bus_a.underflow), 32'd0);
        chk("clr_data_hold", 32'(bus_a.rd_data), 32'hBB);
        // Pointers restart at 0 after clear
        write_a(8'h5A);
        read_a("clr_post_rd", 8'h5A);

        // Wrap-around on DEPTH=5
        for (int i = 0; i < 12; i++) begin
            bus_b.wr_en   = 1'b1;
            bus_b.wr_data = 8'(i);
            tick();
            bus_b.wr_en = 1'b0;
            bus_b.rd_en = 1'b1;
            tick();
            bus_b.rd_en = 1'b0;
            chk("wrap_data", 32'(bus_b.rd_data), 32'(i));
            chk("wrap_valid", 32'(bus_b.rd_valid), 32'd1);
        end
        chk("wrap_empty", 32'(bus_b.empty), 32'd1);

        // Asynchronous reset between edges with a valid read pending
        write_a(8'h66);
        write_a(8'h77);
        bus_a.rd_en = 1'b1;
        tick();
        bus_a.rd_en = 1'b0;
        chk("arst_pre_valid", 32'(bus_a.rd_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus_a.rd_valid), 32'd0);
        chk("arst_data", 32'(bus_a.rd_data), 32'd0);
        chk("arst_level", 32'(bus_a.level), 32'd0);
        chk("arst_empty", 32'(bus_a.empty), 32'd1);
        chk("arst_full", 32'(bus_a.full), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("arst_post_level", 32'(bus_a.level), 32'd0);
        write_a(8'h99);
        read_a("arst_post_rd", 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
